// File: rtl/bf_tape_mem_pkg.sv
// ---------------------------------------------------------------------------
// bf_pkg
// Shared types for the Brainfuck data tape: command encodings carried on the
// tape command bus and the tape controller state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package bf_pkg;

    // Tape commands; value 7 is reserved and behaves as a NOP.
    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_PTR_INC  = 3'd1,
        OP_PTR_DEC  = 3'd2,
        OP_CELL_INC = 3'd3,
        OP_CELL_DEC = 3'd4,
        OP_CELL_WR  = 3'd5,
        OP_CLEAR    = 3'd6,
        OP_RSVD     = 3'd7
    } tape_op_t;

    // Controller states: sequential clear, pointer-move reload, ready.
    typedef enum logic [1:0] {
        CLR,
        LOAD,
        IDLE
    } tape_state_t;

endpackage

// File: rtl/bf_tape_mem_if.sv
// ---------------------------------------------------------------------------
// bf_tape_mem_if
// Command/status bus between the CPU (master) and the data tape (slave).
// Signals:
//   cmd_valid  master->slave  command present
//   cmd_ready  slave->master  command accepted when cmd_valid is also high
//   cmd_op     master->slave  tape_op_t command
//   cmd_wdata  master->slave  value for OP_CELL_WR
//   cell_data  slave->master  current cell, valid whenever cmd_ready=1
//   cell_zero  slave->master  cell_data == 0
//   ptr        slave->master  current data pointer
//   init_done  slave->master  first post-reset clear finished
//   err        slave->master  sticky pointer-range error (bounds build only)
// ---------------------------------------------------------------------------
interface bf_tape_mem_if
    import bf_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);

    logic              cmd_valid;
    logic              cmd_ready;
    tape_op_t          cmd_op;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cell_data;
    logic              cell_zero;
    logic [ADDR_W-1:0] ptr;
    logic              init_done;
    logic              err;

    modport master (
        output cmd_valid, cmd_op, cmd_wdata,
        input  cmd_ready, cell_data, cell_zero, ptr, init_done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_wdata,
        output cmd_ready, cell_data, cell_zero, ptr, init_done, err
    );

endinterface

// File: rtl/bf_tape_mem_sram.sv
// ---------------------------------------------------------------------------
// bf_tape_sram
// Single-port tape storage with synchronous read and write enable, no reset,
// so it maps onto block RAM. Read returns the old contents on a write cycle.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   addr   in  ADDR_W  address for both read and write
//   wdata  in  DATA_W  write data
//   rdata  out DATA_W  registered read data of addr from the previous edge
// ---------------------------------------------------------------------------
module bf_tape_sram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    // Plain write-enable RAM with registered read; deliberately unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bf_tape_mem.sv
// ---------------------------------------------------------------------------
// bf_tape_mem
// Brainfuck data tape: 2**ADDR_W cells of DATA_W bits with a data pointer and
// a cached current cell. Executes > < + - , as single commands over the
// valid/ready bus; the current cell is always readable combinationally.
// After reset and on OP_CLEAR a sequential engine zeroes every cell.
// Optional feature macro: BF_TAPE_BOUNDS_EN -- pointer moves past either end
// are refused and flagged on a sticky err instead of wrapping.
// Ports:
//   clk   in  clock
//   nrst  in  asynchronous active-low reset
//   bus   bf_tape_mem_if.slave command/status bus
// ---------------------------------------------------------------------------
module bf_tape_mem
    import bf_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int PTR_INIT = 0
) (
    input logic          clk,
    input logic          nrst,
    bf_tape_mem_if.slave bus
);

    localparam logic [ADDR_W-1:0] PTR_RST   = ADDR_W'(PTR_INIT);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    tape_state_t       state_q;
    tape_state_t       state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_next;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] cur_cell_q;
    logic [DATA_W-1:0] cell_next;
    logic              init_done_q;
    logic              accept;
    logic              cmd_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    tape_op_t          op;
`ifdef BF_TAPE_BOUNDS_EN
    logic              ptr_oob;
    logic              err_q;
`endif

    assign op     = bus.cmd_op;
    assign accept = (state_q == IDLE) && bus.cmd_valid;

    // Target pointer for a move command; wraps modulo DEPTH unless the
    // bounds build holds the pointer at the end it would run off.
    always_comb begin
        ptr_next = ptr_q;
`ifdef BF_TAPE_BOUNDS_EN
        ptr_oob  = 1'b0;
`endif
        case (op)
            OP_PTR_INC: begin
                ptr_next = ptr_q + 1'b1;
`ifdef BF_TAPE_BOUNDS_EN
                if (ptr_q == ADDR_LAST) begin
                    ptr_oob  = 1'b1;
                    ptr_next = ptr_q;
                end
`endif
            end
            OP_PTR_DEC: begin
                ptr_next = ptr_q - 1'b1;
`ifdef BF_TAPE_BOUNDS_EN
                if (ptr_q == '0) begin
                    ptr_oob  = 1'b1;
                    ptr_next = ptr_q;
                end
`endif
            end
            default: ptr_next = ptr_q;
        endcase
    end

    // New value of the current cell for cell-modifying commands.
    always_comb begin
        case (op)
            OP_CELL_INC: cell_next = cur_cell_q + 1'b1;
            OP_CELL_DEC: cell_next = cur_cell_q - 1'b1;
            OP_CELL_WR:  cell_next = bus.cmd_wdata;
            default:     cell_next = cur_cell_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= CLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear runs DEPTH cycles, pointer moves take one
    // reload cycle, cell ops stay in IDLE so they can issue back to back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR: begin
                if (cnt_q == ADDR_LAST) begin
                    state_d = IDLE;
                end
            end
            LOAD: state_d = IDLE;
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_PTR_INC, OP_PTR_DEC: state_d = LOAD;
                        OP_CLEAR:               state_d = CLR;
                        default:                state_d = IDLE;
                    endcase
                end
            end
            default: state_d = CLR;
        endcase
    end

    // Output/memory-control logic. Cell ops write through to the array so
    // the cached cell and memory never disagree; pointer moves read the new
    // address on the accept edge so LOAD can pick up the data.
    always_comb begin
        cmd_ready = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = ptr_q;
        mem_wdata = cell_next;
        case (state_q)
            CLR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
            end
            IDLE: begin
                cmd_ready = 1'b1;
                if (accept) begin
                    case (op)
                        OP_CELL_INC, OP_CELL_DEC, OP_CELL_WR: mem_we = 1'b1;
                        OP_PTR_INC, OP_PTR_DEC:               mem_addr = ptr_next;
                        default:                              mem_we = 1'b0;
                    endcase
                end
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Datapath registers: pointer, clear counter, cached cell and flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q       <= PTR_RST;
            cnt_q       <= '0;
            cur_cell_q  <= '0;
            init_done_q <= 1'b0;
`ifdef BF_TAPE_BOUNDS_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                CLR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == ADDR_LAST) begin
                        cur_cell_q  <= '0;
                        ptr_q       <= PTR_RST;
                        init_done_q <= 1'b1;
                    end
                end
                LOAD: begin
                    cur_cell_q <= mem_rdata;
                end
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_CELL_INC, OP_CELL_DEC, OP_CELL_WR: begin
                                cur_cell_q <= cell_next;
                            end
                            OP_PTR_INC, OP_PTR_DEC: begin
                                ptr_q <= ptr_next;
`ifdef BF_TAPE_BOUNDS_EN
                                if (ptr_oob) begin
                                    err_q <= 1'b1;
                                end
`endif
                            end
                            OP_CLEAR: begin
                                cnt_q <= '0;
`ifdef BF_TAPE_BOUNDS_EN
                                err_q <= 1'b0;
`endif
                            end
                            default: begin
                                cnt_q <= cnt_q;
                            end
                        endcase
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    bf_tape_sram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_sram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign bus.cmd_ready = cmd_ready;
    assign bus.cell_data = cur_cell_q;
    assign bus.cell_zero = (cur_cell_q == '0);
    assign bus.ptr       = ptr_q;
    assign bus.init_done = init_done_q;
`ifdef BF_TAPE_BOUNDS_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_bf_tape_mem.sv
// ---------------------------------------------------------------------------
// tb_bf_tape_mem
// Self-checking bench for bf_tape_mem (DATA_W=8, ADDR_W=6). A tape model
// (array of cells, pointer, busy-cycle count) tracks what the outputs must
// be; a negedge process compares the DUT against it every cycle. Directed
// sequences pin the model with literal values, then random commands run.
// Honours BF_TAPE_BOUNDS_EN when defined.
// ---------------------------------------------------------------------------
module tb_bf_tape_mem;
    import bf_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
`ifdef BF_TAPE_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    always #5 clk = ~clk;

    bf_tape_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    bf_tape_mem #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .PTR_INIT (0)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Tape model: cell values, pointer, cycles until ready, flags.
    int m_mem [DEPTH];
    int m_ptr;
    int m_busy;
    bit m_init_done;
    bit m_err;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reset leaves the tape clearing for DEPTH cycles; contents end up zero.
    task automatic model_reset();
        m_busy      = DEPTH;
        m_init_done = 1'b0;
        m_ptr       = 0;
        m_err       = 1'b0;
        foreach (m_mem[i]) m_mem[i] = 0;
    endtask

    // Advance the model across one clock edge with the presented command.
    task automatic model_edge(input bit v, input tape_op_t op, input int wd,
                              output bit acc);
        acc = 1'b0;
        if (!nrst) begin
            model_reset();
            return;
        end
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) m_init_done = 1'b1;
            return;
        end
        if (!v) return;
        acc = 1'b1;
        case (op)
            OP_PTR_INC: begin
                if (BOUNDS && m_ptr == DEPTH - 1) m_err = 1'b1;
                else m_ptr = (m_ptr + 1) % DEPTH;
                m_busy = 1;
            end
            OP_PTR_DEC: begin
                if (BOUNDS && m_ptr == 0) m_err = 1'b1;
                else m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
                m_busy = 1;
            end
            OP_CELL_INC: m_mem[m_ptr] = (m_mem[m_ptr] + 1) % 256;
            OP_CELL_DEC: m_mem[m_ptr] = (m_mem[m_ptr] + 255) % 256;
            OP_CELL_WR:  m_mem[m_ptr] = wd % 256;
            OP_CLEAR: begin
                foreach (m_mem[i]) m_mem[i] = 0;
                m_ptr  = 0;
                m_err  = 1'b0;
                m_busy = DEPTH;
            end
            default: ;
        endcase
    endtask

    // Present one command for one clock edge and advance the model.
    task automatic applyStimulus(input bit v, input tape_op_t op, input int wd,
                                 output bit acc);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_wdata = DATA_W'(wd);
        @(posedge clk);
        model_edge(v, op, wd, acc);
        #1;
    endtask

    // Hold a command until accepted, bounded.
    task automatic send(input tape_op_t op, input int wd);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) applyStimulus(1'b1, op, wd, acc);
        if (!acc) checkOutput("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic settle();
        bit acc;
        for (int i = 0; i < 200 && m_busy > 0; i++) applyStimulus(1'b0, OP_NOP, 0, acc);
    endtask

    // Count edges until the DUT reports ready, bounded.
    task automatic count_busy(output int n);
        bit acc;
        n = 0;
        while (!bus.cmd_ready && n < 200) begin
            applyStimulus(1'b0, OP_NOP, 0, acc);
            n++;
        end
    endtask

    // Every-cycle comparison against the model (or reset values in reset).
    always @(negedge clk) begin
        if (!nrst) begin
            checkOutput("rst_ready", 32'(bus.cmd_ready), 32'd0);
            checkOutput("rst_init_done", 32'(bus.init_done), 32'd0);
            checkOutput("rst_err", 32'(bus.err), 32'd0);
        end else begin
            checkOutput("ready", 32'(bus.cmd_ready), 32'(m_busy == 0));
            checkOutput("init_done", 32'(bus.init_done), 32'(m_init_done));
            checkOutput("err", 32'(bus.err), 32'(m_err));
            if (m_busy == 0) begin
                checkOutput("cell_data", 32'(bus.cell_data), 32'(m_mem[m_ptr]));
                checkOutput("cell_zero", 32'(bus.cell_zero), 32'(m_mem[m_ptr] == 0));
                checkOutput("ptr", 32'(bus.ptr), 32'(m_ptr));
            end
        end
    end

    initial begin
        bit acc;
        int n;
        int opi;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_NOP;
        bus.cmd_wdata = '0;
        model_reset();

        // Reset and initial clear.
        repeat (3) applyStimulus(1'b0, OP_NOP, 0, acc);
        nrst = 1'b1;
        count_busy(n);
        checkOutput("init_cycles", 32'(n), 32'd64);
        checkOutput("init_ptr", 32'(bus.ptr), 32'd0);
        checkOutput("init_cell", 32'(bus.cell_data), 32'd0);
        checkOutput("init_done_hi", 32'(bus.init_done), 32'd1);

        // Write, move, write, move back.
        send(OP_CELL_WR, 'h41);
        send(OP_PTR_INC, 0);
        checkOutput("load_ready_lo", 32'(bus.cmd_ready), 32'd0);
        send(OP_CELL_WR, 'h42);
        send(OP_PTR_DEC, 0);
        checkOutput("load_ready_lo2", 32'(bus.cmd_ready), 32'd0);
        settle();
        checkOutput("cell_0x41", 32'(bus.cell_data), 32'h41);
        send(OP_PTR_INC, 0);
        settle();
        checkOutput("cell_0x42", 32'(bus.cell_data), 32'h42);
        checkOutput("ptr_1", 32'(bus.ptr), 32'd1);

        // Cell arithmetic wrap at ptr 0.
        send(OP_PTR_DEC, 0);
        settle();
        send(OP_CELL_WR, 0);
        repeat (3) send(OP_CELL_DEC, 0);
        checkOutput("cell_0xfd", 32'(bus.cell_data), 32'hFD);
        repeat (3) send(OP_CELL_INC, 0);
        checkOutput("cell_wrap_0", 32'(bus.cell_data), 32'h00);
        checkOutput("cell_zero_hi", 32'(bus.cell_zero), 32'd1);

        // Pointer decrement at the lower end.
        send(OP_PTR_DEC, 0);
        settle();
`ifdef BF_TAPE_BOUNDS_EN
        checkOutput("bound_ptr", 32'(bus.ptr), 32'd0);
        checkOutput("bound_err", 32'(bus.err), 32'd1);
        send(OP_CELL_INC, 0);
        send(OP_PTR_INC, 0);
        settle();
        checkOutput("bound_err_sticky", 32'(bus.err), 32'd1);
        send(OP_PTR_DEC, 0);
        settle();
`else
        checkOutput("wrap_ptr_63", 32'(bus.ptr), 32'd63);
        checkOutput("wrap_cell_63", 32'(bus.cell_data), 32'd0);
        send(OP_CELL_WR, 'h5A);
        send(OP_PTR_INC, 0);
        settle();
        checkOutput("wrap_ptr_0", 32'(bus.ptr), 32'd0);
        send(OP_PTR_DEC, 0);
        settle();
        checkOutput("wrap_cell_5a", 32'(bus.cell_data), 32'h5A);
        send(OP_PTR_INC, 0);
        settle();
`endif

        // Fill cells 0..3, then CLEAR.
        for (int i = 0; i < 4; i++) begin
            send(OP_CELL_WR, i + 1);
            send(OP_PTR_INC, 0);
        end
        settle();
        send(OP_CLEAR, 0);
        count_busy(n);
        checkOutput("clear_cycles", 32'(n), 32'd64);
        checkOutput("clear_ptr", 32'(bus.ptr), 32'd0);
        checkOutput("clear_err", 32'(bus.err), 32'd0);
        settle();
        for (int i = 0; i < 4; i++) begin
            checkOutput("cleared_cell", 32'(bus.cell_data), 32'd0);
            send(OP_PTR_INC, 0);
            settle();
        end

        // Randomised command stream; CLEAR kept rare.
        for (int i = 0; i < 600; i++) begin
            opi = int'($urandom_range(0, 7));
            if (opi == 6 && $urandom_range(0, 29) != 0) opi = 3;
            applyStimulus($urandom_range(0, 3) != 0, tape_op_t'(opi),
                          int'($urandom_range(0, 255)), acc);
        end
        settle();

        // Reset pulsed part-way through a clear.
        send(OP_CLEAR, 0);
        repeat (20) applyStimulus(1'b0, OP_NOP, 0, acc);
        nrst = 1'b0;
        #1;
        checkOutput("midrst_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("midrst_init_done", 32'(bus.init_done), 32'd0);
        checkOutput("midrst_ptr", 32'(bus.ptr), 32'd0);
        checkOutput("midrst_cell", 32'(bus.cell_data), 32'd0);
        model_reset();
        applyStimulus(1'b0, OP_NOP, 0, acc);
        nrst = 1'b1;
        count_busy(n);
        checkOutput("reclear_cycles", 32'(n), 32'd64);
        checkOutput("reclear_init_done", 32'(bus.init_done), 32'd1);
        send(OP_CELL_INC, 0);
        checkOutput("post_reset_inc", 32'(bus.cell_data), 32'd1);
        applyStimulus(1'b0, OP_NOP, 0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
